// File: rtl/ctl_bram_arbiter.sv
// Arbitrates the single-port controller BRAM between internal streaming ops (priority) and
// queued CPU writes with a starvation guard. Optional statistics counters: CTL_ARB_STATS_EN.
module ctl_bram_arbiter #(
   parameter int         ADDR_WIDTH     = 8,
   parameter int         FIFO_DEPTH     = 4,
   parameter int         STARVE_LIMIT   = 4,
   parameter int         BRAM_LATENCY   = 1,
   parameter logic [1:0] SEL_CONTROLLER = 2'd1
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  cpu_en_i,
   input  logic                  cpu_we_i,
   input  logic [1:0]            cpu_select_i,
   input  logic [13:0]           cpu_addr_i,
   input  logic [15:0]           cpu_data_i,
   input  logic                  int_req_i,
   input  logic                  int_we_i,
   input  logic [ADDR_WIDTH-1:0] int_addr_i,
   input  logic [15:0]           int_wdata_i,
   output logic                  int_ack_o,
   output logic [15:0]           int_rdata_o,
   output logic                  int_rvalid_o,
   output logic                  bram_en_o,
   output logic                  bram_we_o,
   output logic [ADDR_WIDTH-1:0] bram_addr_o,
   output logic [15:0]           bram_din_o,
   input  logic [15:0]           bram_dout_i,
`ifdef CTL_ARB_STATS_EN
   output logic [15:0]           stat_cpu_wr_o,
   output logic [15:0]           stat_int_grant_o,
   output logic [15:0]           stat_forced_o,
`endif
   output logic                  overflow_o
);

   localparam int                PTR_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int                ENTRY_W  = ADDR_WIDTH + 16;
   localparam logic [PTR_W:0]    FULL_CNT = (PTR_W+1)'(FIFO_DEPTH);
   localparam logic [7:0]        LIMIT    = 8'(STARVE_LIMIT);

   logic [ENTRY_W-1:0]    mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
   logic [PTR_W:0]        cnt_q, cnt_d;
   logic [7:0]            wait_q, wait_d;
   logic                  cpu_wr_prev_q;
   logic                  bram_en_q, bram_we_q;
   logic [ADDR_WIDTH-1:0] bram_addr_q;
   logic [15:0]           bram_din_q;
   logic [BRAM_LATENCY:0] rd_pipe_q;
   logic                  rvalid_q;
   logic [15:0]           rdata_q;
   logic                  overflow_q;

   logic cpu_wr_s, event_s, empty_s, full_s, force_s, grant_int_s, ack_s, pop_s, push_s, drop_s;
   logic [ENTRY_W-1:0] head_s;

   // Event detection on the rising edge of the bus write strobe; one push per WE assertion.
   assign cpu_wr_s    = cpu_en_i & cpu_we_i;
   assign event_s     = cpu_wr_s & ~cpu_wr_prev_q & (cpu_select_i == SEL_CONTROLLER);
   assign empty_s     = (cnt_q == '0);
   assign full_s      = (cnt_q == FULL_CNT);
   assign force_s     = ~empty_s & (wait_q >= LIMIT);
   assign grant_int_s = int_req_i & ~force_s;
   assign ack_s       = grant_int_s & ~rst_i;
   assign pop_s       = ~empty_s & ~grant_int_s;
   assign push_s      = event_s & (~full_s | pop_s);
   assign drop_s      = event_s & full_s & ~pop_s;
   assign head_s      = mem_q[rd_ptr_q];

   // Next-state for the starvation counter and FIFO occupancy.
   always_comb begin
      wait_d = wait_q;
      cnt_d  = cnt_q;
      if (empty_s || pop_s) begin
         wait_d = 8'd0;
      end else if (wait_q != 8'hFF) begin
         wait_d = wait_q + 8'd1;
      end else begin
         wait_d = wait_q;
      end
      case ({push_s, pop_s})
         2'b10:   cnt_d = cnt_q + (PTR_W+1)'(1);
         2'b01:   cnt_d = cnt_q - (PTR_W+1)'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   // Queue storage; contents are don't-care while the pointers say empty.
   always_ff @(posedge clk_i) begin
      if (push_s && !rst_i) begin
         mem_q[wr_ptr_q] <= {cpu_addr_i[ADDR_WIDTH-1:0], cpu_data_i};
      end
   end

   // Grant, BRAM port registers, read-return pipeline and sticky overflow.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cpu_wr_prev_q <= 1'b0;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         cnt_q         <= '0;
         wait_q        <= 8'd0;
         bram_en_q     <= 1'b0;
         bram_we_q     <= 1'b0;
         bram_addr_q   <= '0;
         bram_din_q    <= 16'd0;
         rd_pipe_q     <= '0;
         rvalid_q      <= 1'b0;
         rdata_q       <= 16'd0;
         overflow_q    <= 1'b0;
      end else begin
         cpu_wr_prev_q <= cpu_wr_s;
         cnt_q         <= cnt_d;
         wait_q        <= wait_d;
         if (push_s) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop_s)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         if (ack_s) begin
            bram_en_q   <= 1'b1;
            bram_we_q   <= int_we_i;
            bram_addr_q <= int_addr_i;
            bram_din_q  <= int_wdata_i;
         end else if (pop_s) begin
            bram_en_q   <= 1'b1;
            bram_we_q   <= 1'b1;
            bram_addr_q <= head_s[ENTRY_W-1:16];
            bram_din_q  <= head_s[15:0];
         end else begin
            bram_en_q   <= 1'b0;
            bram_we_q   <= 1'b0;
         end
         // Bit k marks a read whose BRAM enable was k cycles ago.
         rd_pipe_q <= {rd_pipe_q[BRAM_LATENCY-1:0], ack_s & ~int_we_i};
         rvalid_q  <= rd_pipe_q[BRAM_LATENCY];
         if (rd_pipe_q[BRAM_LATENCY]) rdata_q <= bram_dout_i;
         if (drop_s) overflow_q <= 1'b1;
      end
   end

`ifdef CTL_ARB_STATS_EN
   logic [15:0] stat_cpu_wr_q, stat_int_grant_q, stat_forced_q;

   // Saturating activity counters.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         stat_cpu_wr_q    <= 16'd0;
         stat_int_grant_q <= 16'd0;
         stat_forced_q    <= 16'd0;
      end else begin
         if (pop_s && stat_cpu_wr_q != 16'hFFFF) stat_cpu_wr_q <= stat_cpu_wr_q + 16'd1;
         if (ack_s && stat_int_grant_q != 16'hFFFF) stat_int_grant_q <= stat_int_grant_q + 16'd1;
         if (pop_s && force_s && int_req_i && stat_forced_q != 16'hFFFF)
            stat_forced_q <= stat_forced_q + 16'd1;
      end
   end

   assign stat_cpu_wr_o    = stat_cpu_wr_q;
   assign stat_int_grant_o = stat_int_grant_q;
   assign stat_forced_o    = stat_forced_q;
`endif

   assign int_ack_o    = ack_s;
   assign int_rdata_o  = rdata_q;
   assign int_rvalid_o = rvalid_q;
   assign bram_en_o    = bram_en_q;
   assign bram_we_o    = bram_we_q;
   assign bram_addr_o  = bram_addr_q;
   assign bram_din_o   = bram_din_q;
   assign overflow_o   = overflow_q;

endmodule
